x_parity_sched: RTL and testbench

Round-robin scheduler that shares one 32-input XOR reduction unit among 2**IDW requesters. Each granted requester streams a burst of 32-bit words; the block XOR-reduces every accepted word into a running parity bit and returns one parity result per burst, tagged with the requester index. It sits between multiple parity/checksum clients and the single shared wide-XOR datapath, so that only one reduction tree is instantiated.

---
 rtl/x_parity_sched.sv | 215 +++++++++++++++++++++
 tb/tb_x_parity_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/x_parity_sched.sv
// rtl/x_parity_sched.sv - round-robin scheduler sharing one 32-bit XOR reduction among 2**IDW requesters
//
// Purpose: arbitrates burst requests from NREQ clients, streams the granted
// client's words through a single XOR reduction and returns one parity bit per
// completed burst, tagged with the requester index.
//
// Optional feature: define X_PARSCHED_TIMEOUT_EN to abort a burst after 31
// consecutive granted cycles without an accepted beat (reported on o_tout_o).
// Left undefined, a burst waits indefinitely and o_tout_o is tied low.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   req_i       per-requester request, held until its o_valid_o pulse
//   len_i       per-requester burst length minus 1, slice i = [i*LW +: LW]
//   din_i       per-requester data word, slice i = [i*32 +: 32]
//   dvalid_i    per-requester word valid
//   dready_o    per-requester word ready (one-hot or zero)
//   gnt_o       one-hot grant (or zero)
//   o_o         parity of the last completed burst
//   o_valid_o   one-cycle pulse, o_o/o_id_o updated
//   o_id_o      requester index of o_o
//   o_tout_o    one-cycle pulse, burst aborted by timeout
//   busy_o      high while a burst is granted or completing

module x_parity_sched #(
  parameter  int IDW  = 2,
  parameter  int LW   = 4,
  localparam int NREQ = 1 << IDW
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LW-1:0]   len_i,
  input  logic [NREQ*32-1:0]   din_i,
  input  logic [NREQ-1:0]      dvalid_i,
  output logic [NREQ-1:0]      dready_o,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 o_o,
  output logic                 o_valid_o,
  output logic [IDW-1:0]       o_id_o,
  output logic                 o_tout_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;
  logic [LW-1:0]     cnt_q,   cnt_d;
  logic              acc_q,   acc_d;
  logic [IDW-1:0]    last_q,  last_d;
  logic [IDW-1:0]    win_q,   win_d;
  logic              o_q,     o_d;
  logic [IDW-1:0]    o_id_q,  o_id_d;

`ifdef X_PARSCHED_TIMEOUT_EN
  localparam logic [4:0] TOUT_LAST = 5'd30;
  logic [4:0]        tcnt_q,  tcnt_d;
  logic              tout_q,  tout_d;
`endif

  // Round-robin search, starting one past the last served requester.
  logic              arb_found;
  logic [IDW-1:0]    arb_idx;
  logic [IDW-1:0]    arb_cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last_q;
    arb_cand  = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      // k == NREQ wraps back to last_q itself, so it is considered last.
      arb_cand = last_q + IDW'(k);
      if (!arb_found && req_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Datapath: the single shared reduction tree operates on the granted slice.
  logic [31:0]   word_sel;
  logic          word_par;
  logic          beat;
  logic [LW-1:0] len_sel;

  assign word_sel = din_i[int'(win_q)*32 +: 32];
  assign word_par = ^word_sel;
  assign beat     = (state_q == S_BURST) && dvalid_i[win_q];
  assign len_sel  = len_i[int'(arb_idx)*LW +: LW];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    last_d  = last_q;
    win_d   = win_q;
    o_d     = o_q;
    o_id_d  = o_id_q;
`ifdef X_PARSCHED_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tout_d  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          win_d          = arb_idx;
          cnt_d          = len_sel;
          acc_d          = 1'b0;
          state_d        = S_BURST;
`ifdef X_PARSCHED_TIMEOUT_EN
          tcnt_d         = '0;
`endif
        end
      end

      S_BURST: begin
        if (beat && (cnt_q == '0)) begin
          // Final beat wins over a simultaneous request drop. The result is
          // registered here so o_o is already valid in the DONE cycle.
          acc_d   = acc_q ^ word_par;
          o_d     = acc_q ^ word_par;
          o_id_d  = win_q;
          state_d = S_DONE;
        end else if (!req_i[win_q]) begin
          gnt_d   = '0;
          last_d  = win_q;
          state_d = S_IDLE;
        end else if (beat) begin
          acc_d   = acc_q ^ word_par;
          cnt_d   = cnt_q - 1'b1;
`ifdef X_PARSCHED_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end else begin
`ifdef X_PARSCHED_TIMEOUT_EN
          // The 31st consecutive beatless cycle aborts the burst.
          if (tcnt_q == TOUT_LAST) begin
            gnt_d   = '0;
            last_d  = win_q;
            tout_d  = 1'b1;
            tcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            tcnt_d  = tcnt_q + 1'b1;
          end
`endif
        end
      end

      S_DONE: begin
        gnt_d   = '0;
        last_d  = win_q;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      last_q  <= IDW'(NREQ - 1);
      win_q   <= '0;
      o_q     <= 1'b0;
      o_id_q  <= '0;
`ifdef X_PARSCHED_TIMEOUT_EN
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      win_q   <= win_d;
      o_q     <= o_d;
      o_id_q  <= o_id_d;
`ifdef X_PARSCHED_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign dready_o  = (state_q == S_BURST) ? gnt_q : '0;
  assign o_o       = o_q;
  assign o_id_o    = o_id_q;
  assign o_valid_o = (state_q == S_DONE);
  assign busy_o    = (state_q != S_IDLE);
`ifdef X_PARSCHED_TIMEOUT_EN
  assign o_tout_o  = tout_q;
`else
  assign o_tout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_x_parity_sched.sv
// tb/tb_x_parity_sched.sv - directed self-checking bench for x_parity_sched

module tb_x_parity_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [15:0]  len;
  logic [127:0] din;
  logic [3:0]   dvalid;
  logic [3:0]   dready;
  logic [3:0]   gnt;
  logic         o;
  logic         o_valid;
  logic [1:0]   o_id;
  logic         o_tout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  x_parity_sched #(.IDW(2), .LW(4)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .req_i     (req),
    .len_i     (len),
    .din_i     (din),
    .dvalid_i  (dvalid),
    .dready_o  (dready),
    .gnt_o     (gnt),
    .o_o       (o),
    .o_valid_o (o_valid),
    .o_id_o    (o_id),
    .o_tout_o  (o_tout),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [3:0] v);
    len[i*4 +: 4] = v;
  endtask

  task automatic set_din(input int i, input logic [31:0] v);
    din[i*32 +: 32] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req = 4'b0001; set_len(0, 4'd3); dvalid = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL pre_reset_gnt got=%b exp=0001", gnt); end
    tick();
    rst_n = 1'b0; #1;
    checks++;
    if ({gnt, dready, o, o_valid, o_id, o_tout, busy} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset_outputs got gnt=%b dready=%b o=%b ov=%b id=%0d tout=%b busy=%b exp=all zero",
               gnt, dready, o, o_valid, o_id, o_tout, busy);
    end
    tick();
    rst_n = 1'b1; req = 4'b0001; set_len(0, 4'd0); set_din(0, 32'h1); dvalid = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || dready !== 4'b0001) begin errors++; $display("FAIL reset_grant got gnt=%b dready=%b exp=0001", gnt, dready); end
    tick();
    checks++; if (o_valid !== 1'b1 || o !== 1'b1 || o_id !== 2'd0) begin errors++; $display("FAIL reset_result got ov=%b o=%b id=%0d exp ov=1 o=1 id=0", o_valid, o, o_id); end
    req = 4'b0000; dvalid = 4'b0000;
    tick();
    checks++; if (o_valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got ov=%b gnt=%b busy=%b exp 0 0000 0", o_valid, gnt, busy); end
  endtask

  task automatic test_burst();
    logic [31:0] words [4];
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h1; words[2] = 32'h3; words[3] = 32'h7;
    req = 4'b0100; set_len(2, 4'd3); set_din(2, words[0]); dvalid = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || dready !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL burst_grant got gnt=%b dready=%b busy=%b exp 0100 0100 1", gnt, dready, busy); end
    for (int b = 0; b < 4; b++) begin
      set_din(2, words[b]);
      tick();
      if (b < 3) begin
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL burst_early_valid beat=%0d got=%b exp=0", b, o_valid); end
      end else begin
        checks++; if (o_valid !== 1'b1 || o !== 1'b0 || o_id !== 2'd2) begin errors++; $display("FAIL burst_result got ov=%b o=%b id=%0d exp ov=1 o=0 id=2", o_valid, o, o_id); end
      end
    end
    req = 4'b0000; dvalid = 4'b0000;
    tick();
    checks++; if (o_valid !== 1'b0 || o !== 1'b0 || o_id !== 2'd2) begin errors++; $display("FAIL burst_hold got ov=%b o=%b id=%0d exp 0 0 2", o_valid, o, o_id); end
  endtask

  task automatic test_round_robin();
    logic [3:0] par_tbl;
    logic [3:0] exp_gnt;
    par_tbl = 4'b0101;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111; len = 16'h0000; dvalid = 4'b1111;
    set_din(0, 32'h1); set_din(1, 32'h3); set_din(2, 32'h7); set_din(3, 32'h0);
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_grant round=%0d got=%b exp=%b", k, gnt, exp_gnt); end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_id !== 2'(k % 4) || o !== par_tbl[k % 4]) begin
        errors++; $display("FAIL rr_result round=%0d got ov=%b id=%0d o=%b exp ov=1 id=%0d o=%b", k, o_valid, o_id, o, k % 4, par_tbl[k % 4]);
      end
      tick();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap round=%0d got gnt=%b busy=%b exp 0000 0", k, gnt, busy); end
    end
    req = 4'b0000; dvalid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    // Requester 0 asserts dvalid without requesting; it must be ignored.
    req = 4'b0010; set_len(1, 4'd1); set_din(1, 32'h1); set_din(0, 32'h1); dvalid = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0010 || dready !== 4'b0010) begin errors++; $display("FAIL bp_grant got gnt=%b dready=%b exp 0010 0010", gnt, dready); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_after_beat0 got=%b exp=0", o_valid); end
    dvalid[1] = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || gnt !== 4'b0010) begin errors++; $display("FAIL bp_stall got ov=%b gnt=%b exp 0 0010", o_valid, gnt); end
    dvalid[1] = 1'b1; set_din(1, 32'h3);
    tick();
    checks++; if (o_valid !== 1'b1 || o !== 1'b1 || o_id !== 2'd1) begin errors++; $display("FAIL bp_result got ov=%b o=%b id=%0d exp 1 1 1", o_valid, o, o_id); end
    req = 4'b0000; dvalid = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    req = 4'b0010; set_len(1, 4'd3); set_din(1, 32'h1); dvalid = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_grant got=%b exp=0010", gnt); end
    tick();
    req = 4'b0100; set_len(2, 4'd0); set_din(2, 32'h0); dvalid = 4'b0110;
    tick();
    checks++;
    if (gnt !== 4'b0000 || o_valid !== 1'b0 || busy !== 1'b0 || o !== 1'b1 || o_id !== 2'd1 || o_tout !== 1'b0) begin
      errors++; $display("FAIL abort_state got gnt=%b ov=%b busy=%b o=%b id=%0d tout=%b exp 0000 0 0 1 1 0", gnt, o_valid, busy, o, o_id, o_tout);
    end
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_next_grant got=%b exp=0100", gnt); end
    tick();
    checks++; if (o_valid !== 1'b1 || o !== 1'b0 || o_id !== 2'd2) begin errors++; $display("FAIL abort_next_result got ov=%b o=%b id=%0d exp 1 0 2", o_valid, o, o_id); end
    req = 4'b0000; dvalid = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b1000; set_len(3, 4'd0); dvalid = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL tout_grant got=%b exp=1000", gnt); end
`ifdef X_PARSCHED_TIMEOUT_EN
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i < 31) begin
        checks++; if (o_tout !== 1'b0 || gnt !== 4'b1000) begin errors++; $display("FAIL tout_wait cycle=%0d got tout=%b gnt=%b exp 0 1000", i, o_tout, gnt); end
      end else begin
        checks++; if (o_tout !== 1'b1 || gnt !== 4'b0000 || o_valid !== 1'b0) begin errors++; $display("FAIL tout_fire got tout=%b gnt=%b ov=%b exp 1 0000 0", o_tout, gnt, o_valid); end
      end
    end
    req = 4'b0000;
    tick();
    checks++; if (o_tout !== 1'b0) begin errors++; $display("FAIL tout_pulse_width got=%b exp=0", o_tout); end
`else
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++; if (o_tout !== 1'b0 || gnt !== 4'b1000 || busy !== 1'b1) begin errors++; $display("FAIL tout_hold cycle=%0d got tout=%b gnt=%b busy=%b exp 0 1000 1", i, o_tout, gnt, busy); end
    end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || o_valid !== 1'b0) begin errors++; $display("FAIL tout_release got gnt=%b ov=%b exp 0000 0", gnt, o_valid); end
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; len = '0; din = '0; dvalid = '0;
    tick();
    tick();
    test_reset();
    test_burst();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
